// File: rtl/video_sync_gen.sv
// ---------------------------------------------------------------------------
// video_sync_gen
//   Parametrised raster timing generator. Keeps its own pixel (hcnt) and line
//   (vcnt) counters and runs two phase FSMs (ACT -> FP -> SYN -> BP) that
//   produce horizontal/vertical/composite sync, composite blanking, and
//   line/frame start strobes. Every output is a register loaded from the same
//   next-state values as the counters, so all outputs stay cycle-aligned with
//   hcnt/vcnt and there is no combinational input-to-output path.
//
// Optional build macro:
//   INTERLACE_EN - when defined, a field bit toggles on every frame wrap; odd
//                  fields get one extra back-porch line and their vsync is
//                  shifted by half a line. When undefined, field is tied 0.
//
// Ports:
//   CK           in   1   pixel clock
//   RN           in   1   asynchronous active-low reset
//   en           in   1   pixel-advance enable; low freezes counters/outputs
//   sclr         in   1   synchronous restart to (0,0); overrides en
//   hcnt         out  HW  pixel counter, 0..H_TOTAL-1
//   vcnt         out  VW  line counter, 0..V_TOTAL-1 (V_TOTAL in odd field)
//   hphase       out  2   horizontal phase: 0 ACT, 1 FP, 2 SYN, 3 BP
//   vphase       out  2   vertical phase, same encoding
//   hsync        out  1   horizontal sync, polarity set by SYNC_POL
//   vsync        out  1   vertical sync, polarity set by SYNC_POL
//   csync        out  1   composite sync (hsync XOR vsync), polarity SYNC_POL
//   cblank       out  1   high while either phase is outside ACT
//   line_start   out  1   one-cycle pulse when hcnt wraps to 0
//   frame_start  out  1   one-cycle pulse when (hcnt,vcnt) wraps to (0,0)
//   field        out  1   interlace field index
// ---------------------------------------------------------------------------
module video_sync_gen #(
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          en,
  input  logic          sclr,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [1:0]    hphase,
  output logic [1:0]    vphase,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          cblank,
  output logic          line_start,
  output logic          frame_start,
  output logic          field
);

  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYN_START = H_ACTIVE + H_FP;
  localparam int H_BP_START  = H_SYN_START + H_SYNC;
  localparam int V_SYN_START = V_ACTIVE + V_FP;
  localparam int V_BP_START  = V_SYN_START + V_SYNC;

  // Level driven onto a sync pin while that sync is asserted.
  localparam logic ACT_LVL = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    PH_ACT = 2'd0,
    PH_FP  = 2'd1,
    PH_SYN = 2'd2,
    PH_BP  = 2'd3
  } phase_t;

  phase_t          h_state, h_state_nxt;
  phase_t          v_state, v_state_nxt;
  logic [HW-1:0]   h_nxt;
  logic [VW-1:0]   v_nxt;
  logic [VW-1:0]   v_last;
  logic            field_nxt;
  logic            adv, h_wrap, f_wrap;
  logic            hs_act_nxt, vs_act_nxt;

  // sclr takes priority, so a pixel only advances when it is low.
  assign adv    = en & ~sclr;
  assign h_wrap = adv && (hcnt == HW'(H_TOTAL - 1));
  assign f_wrap = h_wrap && (vcnt == v_last);

`ifdef INTERLACE_EN
  // The odd field carries one extra back-porch line.
  assign v_last = field ? VW'(V_TOTAL) : VW'(V_TOTAL - 1);
`else
  assign v_last = VW'(V_TOTAL - 1);
`endif

  // -------------------------------------------------------------------------
  // Counter and field next-state
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    h_nxt     = hcnt;
    v_nxt     = vcnt;
    field_nxt = field;
    if (sclr) begin
      h_nxt     = '0;
      v_nxt     = '0;
      field_nxt = 1'b0;
    end else if (adv) begin
      if (h_wrap) begin
        h_nxt = '0;
        if (f_wrap) begin
          v_nxt = '0;
`ifdef INTERLACE_EN
          field_nxt = ~field;
`endif
        end else begin
          v_nxt = vcnt + 1'b1;
        end
      end else begin
        h_nxt = hcnt + 1'b1;
      end
    end
`ifndef INTERLACE_EN
    field_nxt = 1'b0;
`endif
  end

  // -------------------------------------------------------------------------
  // Phase FSMs: state registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      h_state <= PH_ACT;
      v_state <= PH_ACT;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  // Horizontal FSM: transitions are keyed on the count being entered, so the
  // registered phase lines up with the registered hcnt.
  always_comb begin
    h_state_nxt = h_state;
    if (sclr) begin
      h_state_nxt = PH_ACT;
    end else if (adv) begin
      case (h_state)
        PH_ACT: if (h_nxt == HW'(H_ACTIVE))    h_state_nxt = PH_FP;
        PH_FP:  if (h_nxt == HW'(H_SYN_START)) h_state_nxt = PH_SYN;
        PH_SYN: if (h_nxt == HW'(H_BP_START))  h_state_nxt = PH_BP;
        PH_BP:  if (h_wrap)                    h_state_nxt = PH_ACT;
      endcase
    end
  end

  // Vertical FSM: only moves on a line wrap.
  always_comb begin
    v_state_nxt = v_state;
    if (sclr) begin
      v_state_nxt = PH_ACT;
    end else if (h_wrap) begin
      case (v_state)
        PH_ACT: if (v_nxt == VW'(V_ACTIVE))    v_state_nxt = PH_FP;
        PH_FP:  if (v_nxt == VW'(V_SYN_START)) v_state_nxt = PH_SYN;
        PH_SYN: if (v_nxt == VW'(V_BP_START))  v_state_nxt = PH_BP;
        PH_BP:  if (f_wrap)                    v_state_nxt = PH_ACT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sync decode for the upcoming cycle
  // -------------------------------------------------------------------------
  assign hs_act_nxt = (h_state_nxt == PH_SYN);

`ifdef INTERLACE_EN
  localparam int H_HALF = H_TOTAL / 2;

  // Odd field: the vsync window starts and ends half a line late.
  logic vs_half;
  assign vs_half = ((v_nxt == VW'(V_SYN_START)) && (h_nxt >= HW'(H_HALF))) ||
                   ((v_nxt >  VW'(V_SYN_START)) && (v_nxt <  VW'(V_BP_START))) ||
                   ((v_nxt == VW'(V_BP_START))  && (h_nxt <  HW'(H_HALF)));
  assign vs_act_nxt = field_nxt ? vs_half : (v_state_nxt == PH_SYN);
`else
  assign vs_act_nxt = (v_state_nxt == PH_SYN);
`endif

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~ACT_LVL;
      vsync       <= ~ACT_LVL;
      csync       <= ~ACT_LVL;
      cblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
    end else begin
      hcnt        <= h_nxt;
      vcnt        <= v_nxt;
      hsync       <= hs_act_nxt ? ACT_LVL : ~ACT_LVL;
      vsync       <= vs_act_nxt ? ACT_LVL : ~ACT_LVL;
      csync       <= (hs_act_nxt ^ vs_act_nxt) ? ACT_LVL : ~ACT_LVL;
      cblank      <= !((h_state_nxt == PH_ACT) && (v_state_nxt == PH_ACT));
      // Strobes fire only on a real advance or a restart; a frozen cycle
      // clears them.
      line_start  <= sclr | h_wrap;
      frame_start <= sclr | f_wrap;
      field       <= field_nxt;
    end
  end

  assign hphase = h_state;
  assign vphase = v_state;

endmodule
